// File: rtl/scarv_cop_cpu_bridge.sv
// scarv_cop_cpu_bridge: in-order issue of CPU instructions to the ISE coprocessor and registered return of its responses
module scarv_cop_cpu_bridge #(
  parameter int REQ_DEPTH = 2,
  parameter int MAX_OUT   = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cpu_insn_req,
  output logic        cpu_insn_ack,
  input  logic [31:0] cpu_insn_enc,
  input  logic [31:0] cpu_rs1,
  input  logic [31:0] cpu_rs2,
  input  logic        cpu_flush,
  output logic        cop_insn_valid,
  input  logic        cop_insn_ready,
  output logic [31:0] cop_insn_enc,
  output logic [31:0] cop_rs1,
  output logic [31:0] cop_rs2,
  input  logic        cop_rsp_valid,
  output logic        cop_rsp_ready,
  input  logic [4:0]  cop_rsp_rd,
  input  logic        cop_rsp_wen,
  input  logic [31:0] cop_rsp_data,
  input  logic [2:0]  cop_rsp_status,
  output logic        cpu_rsp_valid,
  input  logic        cpu_rsp_ack,
  output logic [4:0]  cpu_wb_rd,
  output logic        cpu_wb_wen,
  output logic [31:0] cpu_wb_data,
  output logic [2:0]  cpu_rsp_status,
  output logic        halted
);
  localparam int AW = $clog2(REQ_DEPTH);
  localparam logic [2:0] MAX_C = 3'(MAX_OUT);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_nxt;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] enc_mem [REQ_DEPTH];
  logic [31:0] rs1_mem [REQ_DEPTH];
  logic [31:0] rs2_mem [REQ_DEPTH];
  logic [2:0] out_cnt, out_nxt, drop_cnt, drop_nxt;
  logic rsp_full, run, fifo_empty, fifo_full, push, issue;
  logic rsp_take, cpu_hs, fault, discard, load, unhalt;
  assign run = state == RUN;
  assign fifo_empty = wr_ptr == rd_ptr;
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cpu_insn_ack = g_resetn && run && !fifo_full && !cpu_flush;
  assign push = cpu_insn_req && cpu_insn_ack;
  assign cop_insn_valid = !fifo_empty && run && (out_cnt < MAX_C);
  assign issue = cop_insn_valid && cop_insn_ready;
  // Head is forced to zero when empty so stale storage never shows after reset
  assign cop_insn_enc = fifo_empty ? '0 : enc_mem[rd_ptr[AW-1:0]];
  assign cop_rs1 = fifo_empty ? '0 : rs1_mem[rd_ptr[AW-1:0]];
  assign cop_rs2 = fifo_empty ? '0 : rs2_mem[rd_ptr[AW-1:0]];
  assign cop_rsp_ready = g_resetn && (!rsp_full || cpu_rsp_ack);
  assign cpu_rsp_valid = rsp_full;
  assign halted = !run;
  assign cpu_hs = rsp_full && cpu_rsp_ack;
  assign fault = cpu_hs && cpu_rsp_status != 3'd0;
  assign rsp_take = cop_rsp_valid && cop_rsp_ready;
  // Responses after a fault, or owed to pre-flush instructions, are swallowed
  assign discard = rsp_take && (!run || fault || drop_cnt != 3'd0);
  assign load = rsp_take && !discard;
  assign unhalt = !run && cpu_flush;
  always_comb begin
    state_nxt = unhalt ? RUN : fault ? HALTED : state;
    out_nxt = out_cnt + {2'b0, issue} - {2'b0, cpu_hs} - {2'b0, discard};
    drop_nxt = unhalt ? out_nxt : drop_cnt - {2'b0, discard && drop_cnt != 3'd0};
  end
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      out_cnt <= '0;
      drop_cnt <= '0;
      rsp_full <= 1'b0;
      cpu_wb_rd <= '0;
      cpu_wb_wen <= 1'b0;
      cpu_wb_data <= '0;
      cpu_rsp_status <= '0;
    end else begin
      state <= state_nxt;
      out_cnt <= out_nxt;
      drop_cnt <= drop_nxt;
      wr_ptr <= push ? wr_ptr + PTR_ONE : wr_ptr;
      rd_ptr <= cpu_flush ? wr_ptr : issue ? rd_ptr + PTR_ONE : rd_ptr;
      rsp_full <= load || (rsp_full && !cpu_rsp_ack);
      if (load) begin
        cpu_wb_rd <= cop_rsp_rd;
        cpu_wb_wen <= cop_rsp_wen;
        cpu_wb_data <= cop_rsp_data;
        cpu_rsp_status <= cop_rsp_status;
      end
    end
  end
  always_ff @(posedge g_clk) begin
    if (push) begin
      enc_mem[wr_ptr[AW-1:0]] <= cpu_insn_enc;
      rs1_mem[wr_ptr[AW-1:0]] <= cpu_rs1;
      rs2_mem[wr_ptr[AW-1:0]] <= cpu_rs2;
    end
  end
  a_rsp_owed: assert property (@(posedge g_clk) disable iff (!g_resetn) rsp_take |-> out_cnt != 3'd0);
  a_out_max: assert property (@(posedge g_clk) disable iff (!g_resetn) out_cnt <= MAX_C);
endmodule

// File: tb/tb_scarv_cop_cpu_bridge.sv
// tb_scarv_cop_cpu_bridge: scoreboard bench with a behavioural COP model for the CPU/COP bridge
module tb_scarv_cop_cpu_bridge;
  typedef struct packed {logic [4:0] rd; logic wen; logic [31:0] data; logic [2:0] status;} rsp_t;
  typedef struct packed {logic [31:0] enc; logic [31:0] rs1; logic [31:0] rs2;} insn_t;
  typedef struct {logic [31:0] enc; logic [31:0] rs1; logic [31:0] rs2; logic [31:0] data; logic [4:0] rd;} vec_t;
  logic g_clk = 0, g_resetn = 0;
  always #5 g_clk = ~g_clk;
  logic cpu_insn_req = 0, cpu_flush = 0, cop_insn_ready = 0, cpu_rsp_ack = 0, auto_rsp = 0;
  logic [31:0] cpu_insn_enc = 0, cpu_rs1 = 0, cpu_rs2 = 0;
  logic t_valid = 0, m_valid = 0;
  rsp_t t_rsp = '0, m_rsp = '0;
  logic cpu_insn_ack, cop_insn_valid, cop_rsp_ready, cpu_rsp_valid, cpu_wb_wen, halted;
  logic [31:0] cop_insn_enc, cop_rs1, cop_rs2, cpu_wb_data;
  logic [4:0] cpu_wb_rd;
  logic [2:0] cpu_rsp_status;
  logic cop_rsp_valid;
  rsp_t cop_rsp;
  assign cop_rsp_valid = auto_rsp ? m_valid : t_valid;
  assign cop_rsp = auto_rsp ? m_rsp : t_rsp;
  scarv_cop_cpu_bridge #(.REQ_DEPTH(2), .MAX_OUT(2)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack), .cpu_insn_enc(cpu_insn_enc),
    .cpu_rs1(cpu_rs1), .cpu_rs2(cpu_rs2), .cpu_flush(cpu_flush),
    .cop_insn_valid(cop_insn_valid), .cop_insn_ready(cop_insn_ready), .cop_insn_enc(cop_insn_enc),
    .cop_rs1(cop_rs1), .cop_rs2(cop_rs2),
    .cop_rsp_valid(cop_rsp_valid), .cop_rsp_ready(cop_rsp_ready), .cop_rsp_rd(cop_rsp.rd),
    .cop_rsp_wen(cop_rsp.wen), .cop_rsp_data(cop_rsp.data), .cop_rsp_status(cop_rsp.status),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ack(cpu_rsp_ack), .cpu_wb_rd(cpu_wb_rd),
    .cpu_wb_wen(cpu_wb_wen), .cpu_wb_data(cpu_wb_data), .cpu_rsp_status(cpu_rsp_status),
    .halted(halted)
  );
  insn_t iss_q[$];
  rsp_t rsp_q[$];
  rsp_t pend[$];
  insn_t mon_e;
  rsp_t mon_r;
  int total = 0, bad = 0, n_issue = 0, n_rsp = 0, base = 0;
  logic [31:0] fault_enc = '1;
  vec_t tbl[4];
  rsp_t ra, rb;
  function automatic rsp_t model(input logic [31:0] enc);
    rsp_t r;
    r.rd = enc[4:0];
    r.wen = 1'b1;
    r.data = 32'h1111_0000 + {16'h0, enc[15:0]};
    r.status = (enc == fault_enc) ? 3'd3 : 3'd0;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event/timeout want none", nm);
  endtask
  task automatic tick;
    @(posedge g_clk);
    #1;
  endtask
  task automatic send_req(input logic [31:0] e, input logic [31:0] r1, input logic [31:0] r2);
    int n = 0;
    cpu_insn_req = 1; cpu_insn_enc = e; cpu_rs1 = r1; cpu_rs2 = r2;
    @(negedge g_clk);
    while (!cpu_insn_ack && n < 50) begin n++; @(negedge g_clk); end
    if (!cpu_insn_ack) fail_now("req_timeout");
    @(posedge g_clk); #1;
    cpu_insn_req = 0;
  endtask
  task automatic cop_send(input rsp_t r);
    int n = 0;
    t_valid = 1; t_rsp = r;
    @(negedge g_clk);
    while (!cop_rsp_ready && n < 50) begin n++; @(negedge g_clk); end
    if (!cop_rsp_ready) fail_now("cop_rsp_timeout");
    @(posedge g_clk); #1;
    t_valid = 0;
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while ((rsp_q.size() != 0 || pend.size() != 0) && n < 100) begin tick; n++; end
    chk(nm, 96'(rsp_q.size() + pend.size()), 96'd0);
  endtask
  always @(negedge g_clk) begin
    if (g_resetn) begin
      if (cpu_insn_req && cpu_insn_ack) iss_q.push_back({cpu_insn_enc, cpu_rs1, cpu_rs2});
      if (auto_rsp && m_valid && cop_rsp_ready && pend.size() != 0) void'(pend.pop_front());
      if (cop_insn_valid && cop_insn_ready) begin
        n_issue++;
        if (iss_q.size() == 0) fail_now("issue_unexpected");
        else begin
          mon_e = iss_q.pop_front();
          chk("issue", {cop_insn_enc, cop_rs1, cop_rs2}, mon_e);
        end
        if (auto_rsp) pend.push_back(model(cop_insn_enc));
      end
      if (cpu_rsp_valid && cpu_rsp_ack) begin
        n_rsp++;
        if (rsp_q.size() == 0) fail_now("rsp_unexpected");
        else begin
          mon_r = rsp_q.pop_front();
          chk("rsp", 96'({cpu_wb_rd, cpu_wb_wen, cpu_wb_data, cpu_rsp_status}), 96'(mon_r));
        end
      end
    end
  end
  always @(posedge g_clk) begin
    #1;
    m_valid = pend.size() != 0;
    if (m_valid) m_rsp = pend[0];
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      tbl[i].enc = 32'(i);
      tbl[i].rs1 = 32'h5100_0000 + 32'(i);
      tbl[i].rs2 = 32'h5200_0000 + 32'(i);
      tbl[i].data = 32'h1111_0000 + 32'(i);
      tbl[i].rd = 5'(i);
    end
    repeat (2) @(negedge g_clk);
    chk("rst_ack", 96'(cpu_insn_ack), 96'd0);
    chk("rst_rdy", 96'(cop_rsp_ready), 96'd0);
    chk("rst_outs", 96'({cop_insn_valid, cpu_rsp_valid, halted, cop_insn_enc, cpu_wb_data}), 96'd0);
    @(posedge g_clk); #1;
    g_resetn = 1;
    @(negedge g_clk);
    chk("post_rst_ack", 96'({cpu_insn_ack, cop_rsp_ready, cop_insn_valid}), 96'b110);
    // back-to-back
    @(posedge g_clk); #1;
    auto_rsp = 1; cop_insn_ready = 1; cpu_rsp_ack = 1; base = n_rsp;
    for (int i = 0; i < 4; i++) begin
      rsp_q.push_back('{rd: tbl[i].rd, wen: 1'b1, data: tbl[i].data, status: 3'd0});
      send_req(tbl[i].enc, tbl[i].rs1, tbl[i].rs2);
    end
    drain("b2b_drain");
    chk("b2b_count", 96'(n_rsp - base), 96'd4);
    // throttle
    auto_rsp = 0; cpu_rsp_ack = 0; base = n_issue;
    send_req(32'h20, 32'h1, 32'h2);
    send_req(32'h21, 32'h3, 32'h4);
    send_req(32'h22, 32'h5, 32'h6);
    repeat (4) tick;
    @(negedge g_clk);
    chk("thr_issues", 96'(n_issue - base), 96'd2);
    chk("thr_valid", 96'(cop_insn_valid), 96'd0);
    chk("thr_head", 96'(cop_insn_enc), 96'h22);
    @(posedge g_clk); #1;
    rsp_q.push_back(model(32'h20));
    cop_send(model(32'h20));
    @(negedge g_clk);
    chk("thr_rsp_valid", 96'({cpu_rsp_valid, cop_insn_valid}), 96'b10);
    @(posedge g_clk); #1;
    cpu_rsp_ack = 1;
    tick;
    cpu_rsp_ack = 0;
    repeat (2) tick;
    @(negedge g_clk);
    chk("thr_resume", 96'(n_issue - base), 96'd3);
    @(posedge g_clk); #1;
    cpu_rsp_ack = 1;
    rsp_q.push_back(model(32'h21)); cop_send(model(32'h21));
    rsp_q.push_back(model(32'h22)); cop_send(model(32'h22));
    drain("thr_drain");
    // backpressure
    cop_insn_ready = 0; auto_rsp = 1;
    send_req(32'hDEAD_BEEF, 32'h7, 32'h8);
    send_req(32'h0BAD_F00D, 32'h9, 32'hA);
    cpu_insn_req = 1; cpu_insn_enc = 32'h33; cpu_rs1 = 0; cpu_rs2 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge g_clk);
      chk("bp_ack", 96'(cpu_insn_ack), 96'd0);
      chk("bp_hold", 96'({cop_insn_valid, cop_insn_enc}), 96'({1'b1, 32'hDEAD_BEEF}));
    end
    @(posedge g_clk); #1;
    rsp_q.push_back(model(32'hDEAD_BEEF));
    rsp_q.push_back(model(32'h0BAD_F00D));
    rsp_q.push_back(model(32'h33));
    cop_insn_ready = 1;
    for (int n = 0; n < 50 && !cpu_insn_ack; n++) @(negedge g_clk);
    if (!cpu_insn_ack) fail_now("bp_ack_timeout");
    @(posedge g_clk); #1;
    cpu_insn_req = 0;
    drain("bp_drain");
    // exception
    fault_enc = 32'h41;
    rsp_q.push_back(model(32'h40));
    rsp_q.push_back(model(32'h41));
    send_req(32'h40, 0, 0);
    send_req(32'h41, 0, 0);
    send_req(32'h42, 0, 0);
    for (int n = 0; n < 50 && !halted; n++) @(negedge g_clk);
    chk("exc_halted", 96'(halted), 96'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge g_clk);
      chk("exc_quiet", 96'({cpu_rsp_valid, cpu_insn_ack}), 96'd0);
    end
    chk("exc_discard", 96'(pend.size() + rsp_q.size()), 96'd0);
    @(posedge g_clk); #1;
    cpu_flush = 1;
    @(negedge g_clk);
    chk("exc_flush_ack", 96'(cpu_insn_ack), 96'd0);
    @(posedge g_clk); #1;
    cpu_flush = 0; iss_q.delete(); fault_enc = '1;
    @(negedge g_clk);
    chk("exc_unhalt", 96'({halted, cop_insn_valid, cpu_insn_ack}), 96'b001);
    // simultaneous drain and fill
    @(posedge g_clk); #1;
    auto_rsp = 0; cpu_rsp_ack = 0;
    send_req(32'h50, 0, 0);
    send_req(32'h51, 0, 0);
    repeat (2) tick;
    ra = model(32'h50); rb = model(32'h51);
    rsp_q.push_back(ra); cop_send(ra);
    cpu_rsp_ack = 1;
    rsp_q.push_back(rb); cop_send(rb);
    cpu_rsp_ack = 0;
    @(negedge g_clk);
    chk("sim_valid", 96'(cpu_rsp_valid), 96'd1);
    chk("sim_data", 96'(cpu_wb_data), 96'(rb.data));
    @(posedge g_clk); #1;
    cpu_rsp_ack = 1;
    drain("sim_drain");
    // flush while running
    cop_insn_ready = 0;
    send_req(32'h60, 0, 0);
    send_req(32'h61, 0, 0);
    @(negedge g_clk);
    chk("fr_valid", 96'(cop_insn_valid), 96'd1);
    @(posedge g_clk); #1;
    cpu_flush = 1;
    tick;
    cpu_flush = 0; iss_q.delete();
    @(negedge g_clk);
    chk("fr_empty", 96'({cop_insn_valid, cpu_insn_ack, halted}), 96'b010);
    @(posedge g_clk); #1;
    cop_insn_ready = 1;
    repeat (3) tick;
    // reset mid-operation
    cpu_rsp_ack = 0;
    send_req(32'h70, 0, 0);
    repeat (2) tick;
    cop_insn_ready = 0;
    send_req(32'h71, 0, 0);
    send_req(32'h72, 0, 0);
    cop_send(model(32'h70));
    @(negedge g_clk);
    chk("pre_rst", 96'({cpu_rsp_valid, cpu_insn_ack, cop_insn_valid}), 96'b101);
    #2;
    g_resetn = 0;
    #1;
    chk("async_rst", 96'({cpu_rsp_valid, cop_insn_valid, cpu_insn_ack, halted, cpu_wb_rd, cpu_wb_data}), 96'd0);
    chk("async_rst_enc", 96'({cop_insn_enc, cop_rs1, cpu_rsp_status, cpu_wb_wen}), 96'd0);
    iss_q.delete(); rsp_q.delete(); pend.delete();
    @(posedge g_clk); #1;
    g_resetn = 1; auto_rsp = 1; cop_insn_ready = 1; cpu_rsp_ack = 1; base = n_rsp;
    rsp_q.push_back(model(32'h80));
    send_req(32'h80, 32'hAA, 32'hBB);
    drain("rst_resume");
    chk("rst_resume_cnt", 96'(n_rsp - base), 96'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
